// File: rtl/addsub_exec_if.sv
// Request/result handshake bundle for the add/sub execute stage.
// master drives requests and accepts results; slave is the stage.
interface addsub_exec_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_tag,
    input  out_z, out_n, out_v
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_tag,
    output out_z, out_n, out_v
  );
endinterface

// File: rtl/addsub_exec.sv
// Two-stage execute wrapper around the external 32-bit addsub adder.
// Define ADDSUB_EXEC_SAT_EN to saturate ADD/SUB results on overflow.
module addsub_exec #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_exec_if.slave     io,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_cin,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_overflow
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  logic             s1_valid;
  op_e              op1;
  logic [TAG_W-1:0] tag1;

  logic             s2_valid;
  logic [WIDTH-1:0] res_q;
  logic [TAG_W-1:0] tag_q;
  logic             z_q;
  logic             n_q;
  logic             v_q;

  logic             s2_adv;
  logic             ld1;
  logic             ld2;

  assign s2_adv      = !s2_valid || io.out_ready;
  assign ld2         = s1_valid && s2_adv;
  assign io.in_ready = !s1_valid || s2_adv;
  assign ld1         = io.in_valid && io.in_ready;

  // Adder inputs come straight from S1 flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      op1      <= OP_ADD;
      tag1     <= '0;
      as_a     <= '0;
      as_b     <= '0;
      as_cin   <= 1'b0;
    end else if (ld1) begin
      s1_valid <= 1'b1;
      op1      <= op_e'(io.in_op);
      tag1     <= io.in_tag;
      as_a     <= io.in_a;
      as_b     <= (io.in_op == OP_ADD) ? io.in_b : ~io.in_b;
      as_cin   <= (io.in_op != OP_ADD);
    end else if (ld2) begin
      s1_valid <= 1'b0;
    end
  end

  logic             is_arith;
  logic             is_slt;
  logic [WIDTH-1:0] fsrc;
  logic [WIDTH-1:0] res_d;

  assign is_arith = (op1 == OP_ADD) || (op1 == OP_SUB);
  assign is_slt   = (op1 == OP_SLT);

`ifdef ADDSUB_EXEC_SAT_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val = as_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  // fsrc feeds z/n: saturated value for clipped ADD/SUB, raw sum otherwise.
  always_comb begin
    fsrc  = as_sum;
    res_d = '0;
    unique case (1'b1)
      is_arith: begin
`ifdef ADDSUB_EXEC_SAT_EN
        if (as_overflow) fsrc = sat_val;
`endif
        res_d = fsrc;
      end
      is_slt: begin
        res_d = {{(WIDTH-1){1'b0}},
                 as_sum[WIDTH-1] ^ as_overflow};
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      tag_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (ld2) begin
      s2_valid <= 1'b1;
      res_q    <= res_d;
      tag_q    <= tag1;
      z_q      <= (fsrc == '0);
      n_q      <= fsrc[WIDTH-1];
      v_q      <= as_overflow;
    end else if (io.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign io.out_valid  = s2_valid;
  assign io.out_result = res_q;
  assign io.out_tag    = tag_q;
  assign io.out_z      = z_q;
  assign io.out_n      = n_q;
  assign io.out_v      = v_q;

endmodule

// File: tb/tb_addsub_exec.sv
// Directed + scoreboarded bench for addsub_exec with a behavioural adder.
// Honours ADDSUB_EXEC_SAT_EN for expected ADD/SUB values.
module tb_addsub_exec;
  localparam int W  = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_exec_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  logic [W-1:0] as_a, as_b, as_sum;
  logic         as_cin, as_overflow;

  addsub_exec #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (bus),
    .as_a       (as_a),
    .as_b       (as_b),
    .as_cin     (as_cin),
    .as_sum     (as_sum),
    .as_overflow(as_overflow)
  );

  // External adder: modulo sum and signed overflow.
  always_comb begin
    as_sum      = as_a + as_b + {31'b0, as_cin};
    as_overflow = (as_a[31] == as_b[31]) && (as_sum[31] != as_a[31]);
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flg();
    return {29'b0, bus.out_z, bus.out_n, bus.out_v};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  f;
    logic [4:0]  tag;
  } rsp_t;

  req_t items[$];
  rsp_t expq[$];

  function automatic rsp_t model(input req_t r);
    logic [31:0] bb, s, sv;
    logic        ov;
    rsp_t        o;
    bb = (r.op == 2'd0) ? r.b : ~r.b;
    s  = r.a + bb + ((r.op == 2'd0) ? 32'd0 : 32'd1);
    ov = (r.a[31] == bb[31]) && (s[31] != r.a[31]);
    sv = s;
`ifdef ADDSUB_EXEC_SAT_EN
    if (ov && !r.op[1]) sv = r.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    case (r.op)
      2'd0, 2'd1: o.res = sv;
      2'd2:       o.res = ($signed(r.a) < $signed(r.b)) ? 32'd1 : 32'd0;
      default:    o.res = 32'd0;
    endcase
    o.f   = {(sv == 32'd0), sv[31], ov};
    o.tag = r.tag;
    return o;
  endfunction

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] xb,
                        input logic xcin, input logic [31:0] xres,
                        input logic [2:0] xf);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, ".as_a"}, as_a, a);
    chk({nm, ".as_b"}, as_b, xb);
    chk({nm, ".as_cin"}, 32'(as_cin), 32'(xcin));
    chk({nm, ".early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".res"}, bus.out_result, xres);
    chk({nm, ".tag"}, 32'(bus.out_tag), 32'(tag));
    chk({nm, ".zny"}, flg(), 32'(xf));
  endtask

  // mode 0: out_ready held low for 6 cycles; mode 1: random out_ready.
  task automatic stream(input string nm, input int mode, input int rst_at);
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    bit          stall = 0;
    logic [31:0] sres;
    logic [31:0] sf;
    logic [4:0]  stag;
    rsp_t        e;
    expq.delete();
    while ((sent < items.size() || expq.size() != 0) && cyc < 300) begin
      @(negedge clk);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        expq.delete();
        stall = 0;
        chk({nm, ".rst_ov"}, 32'(bus.out_valid), 32'd0);
        chk({nm, ".rst_ir"}, 32'(bus.in_ready), 32'd1);
        cyc++;
        continue;
      end
      rst_n = 1'b1;
      bus.out_ready = (mode == 0) ? (cyc >= 6) : 1'($urandom_range(0, 1));
      if (sent < items.size()) begin
        bus.in_valid = 1'b1;
        bus.in_op    = items[sent].op;
        bus.in_a     = items[sent].a;
        bus.in_b     = items[sent].b;
        bus.in_tag   = items[sent].tag;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        chk({nm, ".hold_res"}, bus.out_result, sres);
        chk({nm, ".hold_tag"}, 32'(bus.out_tag), 32'(stag));
        chk({nm, ".hold_f"}, flg(), sf);
      end
      if (mode == 0 && cyc == 2)
        chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && expq.size() == 0) begin
        chk({nm, ".spurious"}, 32'd1, 32'd0);
      end else if (bus.out_valid && bus.out_ready) begin
        e = expq.pop_front();
        got++;
        chk({nm, ".res"}, bus.out_result, e.res);
        chk({nm, ".tag"}, 32'(bus.out_tag), 32'(e.tag));
        chk({nm, ".zny"}, flg(), 32'(e.f));
      end
      stall = bus.out_valid && !bus.out_ready;
      sres  = bus.out_result;
      stag  = bus.out_tag;
      sf    = flg();
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(items[sent]));
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, ".timeout"}, 32'(cyc < 300), 32'd1);
    chk({nm, ".left"}, 32'(expq.size()), 32'd0);
    if (rst_at < 0)
      chk({nm, ".count"}, 32'(got), 32'(items.size()));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  req_t r;

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'd0;
    bus.in_a      = 32'd5;
    bus.in_b      = 32'd5;
    bus.in_tag    = 5'd1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ov", 32'(bus.out_valid), 32'd0);
    chk("rst.res", bus.out_result, 32'd0);
    chk("rst.tag", 32'(bus.out_tag), 32'd0);
    chk("rst.zny", flg(), 32'd0);
    chk("rst.as_a", as_a, 32'd0);
    chk("rst.as_b", as_b, 32'd0);
    chk("rst.cin", 32'(as_cin), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst.ir", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.quiet", 32'(bus.out_valid), 32'd0);
    end

    run_op("add", 2'd0, 32'd5, 32'd3, 5'd7,
           32'd3, 1'b0, 32'd8, 3'b000);
    run_op("sub", 2'd1, 32'd5, 32'd5, 5'd2,
           32'hFFFF_FFFA, 1'b1, 32'd0, 3'b100);
`ifdef ADDSUB_EXEC_SAT_EN
    run_op("ovf", 2'd0, 32'h7FFF_FFFF, 32'd1, 5'd9,
           32'd1, 1'b0, 32'h7FFF_FFFF, 3'b001);
    run_op("ovfn", 2'd1, 32'h8000_0000, 32'd1, 5'd10,
           32'hFFFF_FFFE, 1'b1, 32'h8000_0000, 3'b011);
`else
    run_op("ovf", 2'd0, 32'h7FFF_FFFF, 32'd1, 5'd9,
           32'd1, 1'b0, 32'h8000_0000, 3'b011);
    run_op("ovfn", 2'd1, 32'h8000_0000, 32'd1, 5'd10,
           32'hFFFF_FFFE, 1'b1, 32'h7FFF_FFFF, 3'b001);
`endif
    run_op("slt", 2'd2, 32'h8000_0000, 32'd1, 5'd3,
           32'hFFFF_FFFE, 1'b1, 32'd1, 3'b001);
    run_op("sltf", 2'd2, 32'd9, 32'd4, 5'd5,
           32'hFFFF_FFFB, 1'b1, 32'd0, 3'b000);
    run_op("cmp", 2'd3, 32'd3, 32'd7, 5'd4,
           32'hFFFF_FFF8, 1'b1, 32'd0, 3'b010);

    items.delete();
    for (int i = 0; i < 4; i++) begin
      r.op  = 2'd0;
      r.a   = 32'(i + 1);
      r.b   = 32'd100;
      r.tag = 5'(i + 1);
      items.push_back(r);
    end
    stream("bp", 0, -1);

    items.delete();
    for (int i = 0; i < 16; i++) begin
      r.op  = 2'($urandom_range(0, 3));
      r.a   = pick();
      r.b   = pick();
      r.tag = 5'(i);
      items.push_back(r);
    end
    stream("rnd", 1, 9);

    items.delete();
    for (int i = 0; i < 16; i++) begin
      r.op  = 2'($urandom_range(0, 3));
      r.a   = pick();
      r.b   = pick();
      r.tag = 5'(i + 16);
      items.push_back(r);
    end
    stream("rnd2", 1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
